// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - programmable beat timer, one-shot or periodic, counting enabled cycles to a terminal value
// Optional prescaler and prescale port compiled in with BEAT_TIMER_PRESCALE_EN.

module beat_timer #(
   parameter int WIDTH     = 28,
   parameter int PRE_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clr,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     period,
`ifdef BEAT_TIMER_PRESCALE_EN
   input  logic [PRE_WIDTH-1:0] prescale,
`endif
   output logic [WIDTH-1:0]     cnt,
   output logic                 busy,
   output logic                 beat_tick,
   output logic                 beat_finish
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_period;
   logic             r_mode;
   logic             r_tick;
   logic             w_pre_tick;
   logic             w_cmd;
   logic             w_adv;

   assign w_cmd = start | stop | clr;
   assign w_adv = (r_state == S_RUN) & en & w_pre_tick & ~w_cmd;

`ifdef BEAT_TIMER_PRESCALE_EN
   logic [PRE_WIDTH-1:0] r_pre;

   assign w_pre_tick = (r_pre == prescale);

   // Prescaler only moves on enabled RUN cycles; a stop cycle leaves it frozen.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pre <= '0;
      end else if (clr || start) begin
         r_pre <= '0;
      end else if ((r_state == S_RUN) && en && !stop) begin
         r_pre <= w_pre_tick ? '0 : r_pre + 1'b1;
      end
   end
`else
   // No prescaler: every enabled RUN cycle is an advance.
   assign w_pre_tick = (PRE_WIDTH > 0);
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_period <= '0;
         r_mode   <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else if (start) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_period <= period;
            r_mode   <= mode;
         end else if (stop) begin
            if (r_state == S_RUN) begin
               r_state <= S_IDLE;
            end
         end else if (w_adv) begin
            if (r_cnt == r_period) begin
               r_tick <= 1'b1;
               if (r_mode) begin
                  r_cnt <= '0;
               end else begin
                  r_state <= S_DONE;
               end
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign cnt         = r_cnt;
   assign busy        = (r_state == S_RUN);
   assign beat_tick   = r_tick;
   assign beat_finish = (r_state == S_DONE);

endmodule

// File: doc/beat_timer.md
# beat_timer

Parametrised successor to the beat counter used by the buzzer/music path. It counts enabled clock cycles (or prescaled ticks) up to a programmable terminal value. It supports one-shot mode (saturating finish, as the old counter did) and periodic mode (auto-restart with a tick pulse per period). It is started, stopped and cleared by single-cycle commands from the APB/AHB peripheral register block and feeds note/beat sequencing logic.

## Interface
- WIDTH, 28: width of counter and period.
- PRE_WIDTH, 8: width of prescale input (used only when prescaler compiled in).

- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; low freezes counting and prescaler, commands still honoured.
- start  in  1  one-cycle command: sample period/mode, zero counter, enter RUN.
- stop  in  1  one-cycle command: RUN -> IDLE, counter holds.
- clr  in  1  one-cycle command: counter 0, state IDLE, outputs deasserted.
- mode  in  1  0 = one-shot, 1 = periodic; sampled only on start.
- period  in  WIDTH  terminal count; sampled only on start into period_q.
- prescale  in  PRE_WIDTH  advance every prescale+1 enabled cycles (present only with BEAT_TIMER_PRESCALE_EN).
- cnt  out  WIDTH  current count.
- busy  out  1  high in RUN.
- beat_tick  out  1  one-cycle pulse per terminal count.
- beat_finish  out  1  level, high in DONE (one-shot completed).

## Operation
- States: IDLE, RUN, DONE. Reset/clr -> IDLE.
- Command priority per cycle: clr > start > stop > advance.
- start (any state, incl. RUN/DONE): cnt<=0, period_q<=period, mode_q<=mode, prescaler<=0, state RUN. Restart in RUN is legal.
- stop: RUN -> IDLE, cnt/period_q held; ignored in IDLE/DONE.
- Advance = RUN & en & prescaler tick (tick every enabled cycle when prescaler absent).
- On advance with cnt != period_q: cnt<=cnt+1.
- On advance with cnt == period_q (terminal): beat_tick<=1 next cycle; one-shot -> DONE, cnt holds at period_q; periodic -> cnt<=0, stay RUN.
- Terminal is reached after period_q+1 advances; period_q=0 terminates on first advance.
- cnt never exceeds period_q; no wrap at 2^WIDTH possible (max period = 2^WIDTH-1).
- DONE persists until start or clr; beat_finish = (state==DONE).
- busy = (state==RUN).
- Advance is suppressed in any cycle carrying start, stop or clr.

## Timing
- Reset values: cnt 0, busy 0, beat_tick 0, beat_finish 0, state IDLE, period_q 0, mode_q 0, prescaler 0; rstn low clears immediately (async), mid-run included.
- All outputs registered/decoded from registers; no combinational path from inputs to outputs.
- start at edge N (en=1, no prescale): busy=1, cnt=0 from N+1; cnt=k at N+1+k; terminal advance at edge N+1+period; beat_tick, and beat_finish (one-shot), high after edge N+2+period.
- Periodic: beat_tick pulses every period+1 advances; cnt reads 0 in the tick cycle.
- stop at edge M: busy low after M; no tick generated by that cycle even if terminal.
- clr with start same cycle: clr wins, IDLE.

## Configuration
- BEAT_TIMER_PRESCALE_EN defined: prescale port and PRE_WIDTH-bit prescaler exist. Prescaler counts enabled RUN cycles, generates an advance when it equals prescale, then reloads to 0. It is cleared on start/clr/reset and frozen when en=0.
- Undefined: no prescale port, no prescaler register; every RUN cycle with en=1 is an advance.

## Test plan
- rstn asserted mid-RUN with period=10 at cnt=4 -> cnt, busy, beat_tick, beat_finish all 0 immediately; IDLE after release.
- One-shot, period=5, en=1, start at edge 0 -> cnt 0..5 over edges 1..6; beat_tick single pulse and beat_finish high after edge 7; cnt holds 5, busy 0 until clr.
- Periodic, period=3, start at edge 0 -> beat_tick after edges 5, 9, 13; stop at edge 10 -> busy 0, cnt holds 1, no further ticks.
- One-shot, period=2, en toggling 1/0 each cycle -> terminal on 3rd enabled cycle; cnt frozen during en=0 cycles.
- clr and start same cycle -> IDLE, cnt 0. start in RUN at cnt=7 with new period=1 -> cnt 0, finish two advances later.
- With BEAT_TIMER_PRESCALE_EN, prescale=1, period=2, one-shot -> beat_finish after 6 enabled RUN cycles; en=0 stretches it cycle-for-cycle.
